pl_stage_chain: RTL and testbench
=================================

Name: pl_stage_chain

Overview:
Parametrised elastic pipeline-register chain that replaces fixed, always-enabled stage registers in the pipelined MIPS core. It has NUM_STAGES stages, each holding one DATA_WIDTH payload and a valid bit. Valid/ready handshaking runs at both ends, with per-stage hold (stall) and per-stage flush (kill). It lets the core insert bubbles for load-use and branch hazards, and it reports occupancy and stall statistics.

Parameters:
- NUM_STAGES, 4, number of register stages (must be >= 1); stage 0 is youngest, stage NUM_STAGES-1 is oldest.
- DATA_WIDTH, 32, payload bits per stage.
- STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the chain is in reset while reset=0.
- in_valid  input  1  upstream offers in_data.
- in_data  input  DATA_WIDTH  payload entering stage 0.
- in_ready  output  1  stage 0 can accept this cycle.
- hold_mask  input  NUM_STAGES  bit i=1 freezes stage i this cycle.
- flush_mask  input  NUM_STAGES  bit i=1 empties stage i at the next edge.
- out_valid  output  1  valid bit of stage NUM_STAGES-1.
- out_data  output  DATA_WIDTH  data of stage NUM_STAGES-1.
- out_ready  input  1  downstream accepts out_data.
- stage_valid  output  NUM_STAGES  per-stage valid bits, for hazard logic.
- occupancy  output  $clog2(NUM_STAGES+1)  count of valid stages.
- stall_count  output  STALL_CNT_WIDTH  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset (reset=0, async): all valid bits=0, all stage data=0, stall_count=0. Outputs follow immediately: out_valid=0, in_ready=1, occupancy=0, stage_valid=0, out_data=0. Asserting reset mid-operation discards all contents with no drain.
- Ready chain, combinational from registered state and inputs:
  - ready_N = out_ready.
  - adv_i = valid_i & !hold_mask[i] & ready_{i+1}.
  - ready_i = !valid_i | adv_i (defined for all i, including the last stage).
  - in_ready = ready_0.
- Transfer into stage i (i > 0): occurs when ready_i=1 and adv_{i-1}=1. Stage i then loads data_{i-1} and sets valid_i=1. Transfer into stage 0: in_valid & ready_0.
- Stage i state at each edge, applied in priority order:
  1. flush_mask[i]=1: valid_i <= 0; data unchanged. Flush overrides hold and overrides any incoming transfer; the incoming item is lost.
  2. Transfer into stage i: load the new data and set valid_i <= 1.
  3. adv_i=1 with no transfer in: valid_i <= 0 (bubble).
  4. Otherwise: hold data and valid.
- An item leaving stage i under adv_i is unaffected by flush_mask[i]; it lands in stage i+1 unless flush_mask[i+1]=1.
- Data registers load only on a transfer. A bubble keeps stale data, with valid=0.
- Latency: an accepted item appears at out_valid NUM_STAGES edges after acceptance when no hold, flush or backpressure occurs. Throughput is 1 item per cycle.
- Full chain with out_ready=1: throughput is sustained, because ready propagates from the output.
- Order is preserved; no item is ever duplicated.
- hold_mask[i] on an empty stage has no effect on ready_i (ready_i=1).
- A hold on stage i blocks all older-to-younger propagation behind it once the stages behind it fill. Stages older than i drain and become bubbles.
- The output handshake completes on out_valid & out_ready with no hold on the last stage. hold_mask[NUM_STAGES-1]=1 suppresses the output transfer even if out_ready=1; out_valid stays 1.
- occupancy equals the registered popcount of the valid bits.
- stall_count increments by 1 at each edge where in_valid & !in_ready, and saturates at all-ones.

Decomposition:
- Shared package pl_chain_pkg holds:
  - stage-index width function (clog2);
  - defaults for NUM_STAGES, DATA_WIDTH and STALL_CNT_WIDTH;
  - the flush-over-hold priority as a documented constant.
- One sub-module, pl_stage: a single stage holding data+valid, with inputs hold, flush, load_en, load_data and ready_next, and outputs valid, data and ready. pl_stage_chain instantiates NUM_STAGES of these in a generate loop and adds the occupancy and stall counter logic.

Test Plan:
All scenarios use NUM_STAGES=4, DATA_WIDTH=32.
- Stream 0x10,0x11,0x12,... with in_valid=1, out_ready=1, masks=0 -> 0x10 appears at out_valid 4 edges after acceptance; then one item per cycle in order; in_ready stays 1; occupancy=4 in steady state.
- Feed 6 items with out_ready=0 -> exactly 4 accepted; in_ready=0 afterwards; occupancy=4; stall_count increments each blocked cycle. Then set out_ready=1 -> outputs 0x10..0x15 in order with no loss or duplicates.
- Full chain streaming; hold_mask=4'b0010 for 1 cycle -> stages 0 and 1 frozen, stage 2 becomes a bubble, stage 3 drains. Output shows exactly one gap, then resumes in order.
- Chain holds 0xA0(s0),0xA1(s1),0xA2(s2),0xA3(s3); flush_mask=4'b0011 with out_ready=0 -> next edge: stage_valid=4'b1100, occupancy=2. Apply the same flush with out_ready=1 and in_valid=0 -> 0xA0 and 0xA1 never appear at the output.
- hold_mask[1]=1 and flush_mask[1]=1 in the same cycle -> stage 1 valid=0 after the edge (flush wins).
- Assert reset low between edges with the chain full -> out_valid=0, occupancy=0, stall_count=0 without a clock edge. Release reset -> in_ready=1 on the first cycle.

Source files
------------

// File: rtl/pl_chain_pkg.sv
// Shared definitions for the elastic pipeline-register chain.
//   clog2()           : index/count width helper used for port sizing
//   DEF_*             : default chain geometry
//   FLUSH_OVER_HOLD   : a stage with both flush and hold set empties at the
//                       next edge; flush also beats an incoming transfer
package pl_chain_pkg;

    localparam int DEF_NUM_STAGES      = 4;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_STALL_CNT_WIDTH = 16;

    // Flush wins over hold and over a transfer arriving in the same cycle;
    // pl_stage evaluates flush first for this reason.
    localparam bit FLUSH_OVER_HOLD = 1'b1;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pl_stage.sv
// One elastic pipeline stage: a payload register plus its valid bit.
// Ports:
//   clk, reset      : rising-edge clock, async active-low reset
//   hold            : freeze this stage for the current cycle
//   flush           : empty this stage at the next edge (beats hold/load)
//   load_en         : a transfer into this stage happens at the next edge
//   load_data       : payload captured on load_en
//   ready_next      : ready of the next-older stage (or downstream)
//   valid, data     : registered stage contents
//   adv             : the held item leaves this stage at the next edge
//   ready           : this stage can take a new item at the next edge
module pl_stage
    import pl_chain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready_next,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  adv,
    output logic                  ready
);

    // An empty stage is always ready regardless of hold.
    assign adv   = valid & ~hold & ready_next;
    assign ready = ~valid | adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            // Incoming item (if any) is dropped; data is left stale.
            valid <= 1'b0;
        end else if (load_en) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (adv) begin
            // Item moved on and nothing replaced it: bubble, stale data.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pl_stage_chain.sv
// Elastic pipeline-register chain with valid/ready at both ends, per-stage
// hold and flush, occupancy and saturating stall statistics.
// Stage 0 is youngest, stage NUM_STAGES-1 is oldest and drives the output.
// Ports:
//   clk, reset             : rising-edge clock, async active-low reset
//   in_valid/in_data/in_ready    : upstream handshake into stage 0
//   hold_mask, flush_mask  : per-stage freeze / empty controls
//   out_valid/out_data/out_ready : downstream handshake from last stage
//   stage_valid            : per-stage valid bits for hazard logic
//   occupancy              : number of valid stages
//   stall_count            : saturating count of in_valid & !in_ready cycles
module pl_stage_chain
    import pl_chain_pkg::*;
#(
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int STALL_CNT_WIDTH = DEF_STALL_CNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    input  logic [NUM_STAGES-1:0]             hold_mask,
    input  logic [NUM_STAGES-1:0]             flush_mask,
    output logic                              out_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    input  logic                              out_ready,
    output logic [NUM_STAGES-1:0]             stage_valid,
    output logic [clog2(NUM_STAGES+1)-1:0]    occupancy,
    output logic [STALL_CNT_WIDTH-1:0]        stall_count
);

    localparam int OCC_W = clog2(NUM_STAGES + 1);

    // Each stage keeps its own handshake nets so the ready chain (which runs
    // oldest -> youngest) is a chain of distinct signals rather than bits of
    // one vector feeding back into itself.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        logic                  rdy;
        logic                  rdy_next;
        logic                  advance;
        logic                  vld;
        logic                  ld;
        logic [DATA_WIDTH-1:0] q;
        logic [DATA_WIDTH-1:0] src;

        if (g == NUM_STAGES - 1) begin : g_last
            assign rdy_next = out_ready;
        end else begin : g_mid
            assign rdy_next = g_stage[g+1].rdy;
        end

        if (g == 0) begin : g_first
            assign ld  = in_valid & rdy;
            assign src = in_data;
        end else begin : g_rest
            assign ld  = g_stage[g-1].advance & rdy;
            assign src = g_stage[g-1].q;
        end

        pl_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .hold       (hold_mask[g]),
            .flush      (flush_mask[g]),
            .load_en    (ld),
            .load_data  (src),
            .ready_next (rdy_next),
            .valid      (vld),
            .data       (q),
            .adv        (advance),
            .ready      (rdy)
        );

        assign stage_valid[g] = vld;
    end

    assign in_ready  = g_stage[0].rdy;
    assign out_valid = g_stage[NUM_STAGES-1].vld;
    assign out_data  = g_stage[NUM_STAGES-1].q;

    // Popcount of the registered valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            occupancy = occupancy + OCC_W'(stage_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pl_stage_chain.sv
// Directed bench for pl_stage_chain (4 stages, 32-bit payload): a vector
// table for streaming/drain plus hand-written multi-cycle sequences for
// backpressure, hold, flush, flush-vs-hold and asynchronous reset.
module tb_pl_stage_chain;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [NS-1:0] hold_mask;
    logic [NS-1:0] flush_mask;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [NS-1:0] stage_valid;
    logic [2:0]    occupancy;
    logic [SW-1:0] stall_count;

    always #5 clk = ~clk;

    pl_stage_chain #(
        .NUM_STAGES      (NS),
        .DATA_WIDTH      (DW),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .hold_mask   (hold_mask),
        .flush_mask  (flush_mask),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic [NS-1:0] hold;
        logic [NS-1:0] flush;
        logic          e_irdy;   // in_ready before the edge
        logic [NS-1:0] e_sv;     // after the edge
        logic [2:0]    e_occ;
        logic          e_ov;
        logic [DW-1:0] e_od;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        hold_mask  = '0;
        flush_mask = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[10];
        logic [DW-1:0] got[$];
        logic          acc;
        logic [DW-1:0] ptr;
        int            gaps, run;
        bit            seen;

        idle();
        #12;
        // ---------------- reset state ----------------
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        do_reset();

        // ---------------- streaming table ----------------
        tbl[0] = '{1'b1, 32'h10, 1'b1, 4'h0, 4'h0, 1'b1, 4'b0001, 3'd1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h11, 1'b1, 4'h0, 4'h0, 1'b1, 4'b0011, 3'd2, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h12, 1'b1, 4'h0, 4'h0, 1'b1, 4'b0111, 3'd3, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h13, 1'b1, 4'h0, 4'h0, 1'b1, 4'b1111, 3'd4, 1'b1, 32'h10};
        tbl[4] = '{1'b1, 32'h14, 1'b1, 4'h0, 4'h0, 1'b1, 4'b1111, 3'd4, 1'b1, 32'h11};
        tbl[5] = '{1'b1, 32'h15, 1'b1, 4'h0, 4'h0, 1'b1, 4'b1111, 3'd4, 1'b1, 32'h12};
        tbl[6] = '{1'b1, 32'h16, 1'b1, 4'h0, 4'h0, 1'b1, 4'b1111, 3'd4, 1'b1, 32'h13};
        tbl[7] = '{1'b1, 32'h17, 1'b1, 4'h0, 4'h0, 1'b1, 4'b1111, 3'd4, 1'b1, 32'h14};
        tbl[8] = '{1'b0, 32'h0,  1'b1, 4'h0, 4'h0, 1'b1, 4'b1110, 3'd3, 1'b1, 32'h15};
        tbl[9] = '{1'b0, 32'h0,  1'b1, 4'h0, 4'h0, 1'b1, 4'b1100, 3'd2, 1'b1, 32'h16};

        for (int k = 0; k < 10; k++) begin
            in_valid   = tbl[k].iv;
            in_data    = tbl[k].id;
            out_ready  = tbl[k].ordy;
            hold_mask  = tbl[k].hold;
            flush_mask = tbl[k].flush;
            #1;
            chk($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].e_irdy));
            step();
            chk($sformatf("tbl%0d_stage_valid", k), 32'(stage_valid), 32'(tbl[k].e_sv));
            chk($sformatf("tbl%0d_occupancy", k), 32'(occupancy), 32'(tbl[k].e_occ));
            chk($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
            if (tbl[k].e_ov) chk($sformatf("tbl%0d_out_data", k), out_data, tbl[k].e_od);
        end

        // ---------------- backpressure: 6 offered, 4 fit ----------------
        do_reset();
        idle();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h10 + 32'(k);
            #1;
            chk("bp_fill_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_data = 32'h14;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_blocked_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("bp_occupancy", 32'(occupancy), 32'd4);
        chk("bp_stall_count", 32'(stall_count), 32'd2);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                if (in_data == 32'h14) in_data = 32'h15;
                else in_valid = 1'b0;
            end
        end
        chk("bp_out_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size() && i < 6; i++)
            chk($sformatf("bp_out%0d", i), got[i], 32'h10 + 32'(i));
        chk("bp_stall_final", 32'(stall_count), 32'd2);

        // ---------------- one-cycle hold on stage 1 ----------------
        do_reset();
        idle();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ptr       = 32'h20;
        in_data   = ptr;
        for (int k = 0; k < 4; k++) begin
            step();
            ptr = ptr + 1;
            in_data = ptr;
        end
        hold_mask = 4'b0010;
        got.delete();
        gaps = 0; run = 0; seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (c == 0) chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                got.push_back(out_data);
                if (seen) gaps += run;
                run = 0;
                seen = 1'b1;
            end else if (seen) begin
                run++;
            end
            acc = in_valid && in_ready;
            step();
            if (c == 0) begin
                hold_mask = '0;
                chk("hold_stage_valid", 32'(stage_valid), 32'b1011);
            end
            if (acc) begin
                ptr = ptr + 1;
                if (ptr > 32'h2B) in_valid = 1'b0;
                else in_data = ptr;
            end
        end
        chk("hold_gap_count", 32'(gaps), 32'd1);
        chk("hold_out_count", 32'(got.size()), 32'd12);
        for (int i = 0; i < got.size() && i < 12; i++)
            chk($sformatf("hold_out%0d", i), got[i], 32'h20 + 32'(i));

        // ---------------- flush stages 0 and 1 ----------------
        do_reset();
        idle();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hA3 - 32'(k);
            step();
        end
        in_valid = 1'b0;
        chk("flush_full", 32'(stage_valid), 32'b1111);
        flush_mask = 4'b0011;
        step();
        chk("flush_stage_valid", 32'(stage_valid), 32'b1100);
        chk("flush_occupancy", 32'(occupancy), 32'd2);
        chk("flush_out_data", out_data, 32'hA3);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            step();
        end
        flush_mask = '0;
        chk("flush_out_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("flush_out0", got[0], 32'hA3);
            chk("flush_out1", got[1], 32'hA2);
        end
        chk("flush_drained_occ", 32'(occupancy), 32'd0);

        // ---------------- hold and flush on the same stage ----------------
        do_reset();
        idle();
        in_valid = 1'b1;
        in_data  = 32'h50;
        step();
        in_data  = 32'h51;
        step();
        in_valid = 1'b0;
        chk("hf_pre_stage_valid", 32'(stage_valid), 32'b0011);
        hold_mask  = 4'b0010;
        flush_mask = 4'b0010;
        step();
        hold_mask  = '0;
        flush_mask = '0;
        chk("hf_stage_valid", 32'(stage_valid), 32'b0001);
        chk("hf_occupancy", 32'(occupancy), 32'd1);

        // ---------------- async reset with chain full ----------------
        do_reset();
        idle();
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'h60 + 32'(k);
            step();
        end
        chk("ar_pre_occ", 32'(occupancy), 32'd4);
        chk("ar_pre_stall", 32'(stall_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_occupancy", 32'(occupancy), 32'd0);
        chk("ar_stall", 32'(stall_count), 32'd0);
        chk("ar_stage_valid", 32'(stage_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_rel_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("ar_rel_stage_valid", 32'(stage_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
